fifo_prog: RTL and testbench
============================

# fifo_prog

Parametrised synchronous FIFO, the next generation of the team's `fifo` block. It adds configurable width and depth, programmable almost-full and almost-empty thresholds, and a live occupancy count. It also adds a synchronous flush and an optional first-word-fall-through (FWFT) read mode. It sits behind the existing `fifo` interface (generalised with matching parameters) and is driven by the constrained-random FIFO bench.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of `data_in` and `data_out`.
- `DEPTH`, 8: number of entries. Must be a power of two and ≥ 4.
- `AF_THRESH`, `DEPTH-1`: `almostfull` asserts when `count >= AF_THRESH`.
- `AE_THRESH`, 1: `almostempty` asserts when `count <= AE_THRESH`.
- `FWFT`, 0: read mode. 0 = registered read; 1 = first-word-fall-through.
- Legality rule: `1 <= AE_THRESH < AF_THRESH <= DEPTH-1`. Any violation is an elaboration-time fatal.

Ports (clock and reset first):
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `flush`, in, 1: synchronous clear of FIFO contents.
- `wr_en`, in, 1: write request.
- `data_in`, in, `DATA_WIDTH`: write data.
- `rd_en`, in, 1: read request.
- `data_out`, out, `DATA_WIDTH`: read data.
- `wr_ack`, out, 1: the previous edge accepted a write.
- `overflow`, out, 1: the previous edge rejected a write because the FIFO was full.
- `underflow`, out, 1: the previous edge rejected a read because the FIFO was empty.
- `full`, out, 1: `count == DEPTH`.
- `empty`, out, 1: `count == 0`.
- `almostfull`, out, 1: `count >= AF_THRESH`.
- `almostempty`, out, 1: `count <= AE_THRESH`.
- `count`, out, `$clog2(DEPTH)+1`: current occupancy.

## Operation
- Write acceptance: `wr_acc = wr_en && !full && !flush`.
- Read acceptance: `rd_acc = rd_en && !empty && !flush`.
- Both requests evaluate against the flags as they stand before the edge. There is no pass-through at full or empty.
- Count update: `count` increments on `wr_acc` only, decrements on `rd_acc` only, and is unchanged when both are accepted.
- Pointers: `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits and wrap naturally from `DEPTH-1` to 0.
- Both requested while full: only the read is accepted; `overflow=1`, `wr_ack=0`.
- Both requested while empty: only the write is accepted; `underflow=1`, `wr_ack=1`.
- Flush behaviour:
  - `flush` has priority over `wr_en` and `rd_en`.
  - On the flush edge: pointers and `count` go to 0; `wr_ack`, `overflow` and `underflow` go to 0.
  - Storage contents are not cleared.
  - With `FWFT=0`, `data_out` holds its value.
- Read data, `FWFT=0`: `data_out` registers `mem[rd_ptr]` on each `rd_acc` edge and holds otherwise.
- Read data, `FWFT=1`: `data_out` is combinationally `mem[rd_ptr]` whenever `!empty`, and 0 when empty. `rd_acc` pops the head entry.
- Flags: `full`, `empty`, `almostfull` and `almostempty` are combinational decodes of `count`.
- Reset values:
  - `count`, both pointers, `data_out`, `wr_ack`, `overflow`, `underflow`: 0.
  - `empty=1`, `almostempty=1`, `full=0`, `almostfull=0`.
- Reset mid-operation: asserting `rst_n` low clears state immediately, regardless of `clk`. Stored data is lost logically.

## Timing
- `wr_ack`, `overflow`, `underflow` and (for `FWFT=0`) `data_out` are registered. Each is valid in the cycle after the edge that sampled the request, and each is a single-cycle pulse per request.
- Flags and `count` reflect the new occupancy immediately after the edge.
- Write-to-read latency:
  - `FWFT=0`: a write at edge N can be read at edge N+1, with data on `data_out` after edge N+1.
  - `FWFT=1`: a write at edge N into an empty FIFO appears on `data_out` after edge N with no `rd_en`.
- Sustained throughput: one write and one read per cycle.

## Structure
- `fifo_pkg` holds:
  - the default constants `FIFO_DATA_WIDTH=16` and `FIFO_DEPTH=8`;
  - a `count_t` helper width function;
  - the bench transaction class, extended with `flush` and the new flags.
- `share_pkg` keeps the existing `test_finsh` end-of-test handshake.
- Sub-module `fifo_mem`:
  - simple dual-port array, `DEPTH x DATA_WIDTH`;
  - synchronous write port, asynchronous read port;
  - no reset on storage.
- The top level owns pointers, count, flags and output registers.

## Test plan
All scenarios use `DEPTH=8`, `DATA_WIDTH=16` unless stated.
- **Reset mid-stream:** 5 writes, then drop `rst_n` between edges → `count=0`, `empty=1`, `almostempty=1`, `data_out=0` immediately.
- **Fill and overflow:** writes of 0..7 → `wr_ack=1` after each write; `almostfull` after the 7th; `full` after the 8th. A 9th write → `overflow=1`, `wr_ack=0`, `count` stays 8.
- **Drain and underflow, `FWFT=0`:** 8 reads → `data_out` = 0..7 in order, one cycle after each `rd_en`. A 9th read → `underflow=1`, `data_out` holds 7.
- **Simultaneous requests:**
  - at `count=8`: both requested → `count=7`, `overflow=1`;
  - at `count=0`: both requested → `count=1`, `underflow=1`, `wr_ack=1`;
  - at `count=4`: both requested → `count=4`, `wr_ack=1`.
- **Flush and FWFT:**
  - Flush at `count=5` with `wr_en=1` → next cycle `count=0`, `empty=1`, `wr_ack=0`.
  - `FWFT=1`: write `16'hA5A5` into an empty FIFO → `data_out=16'hA5A5` after one edge, with no `rd_en`.
- **Random soak:** 30000 random cycles of `wr_en`/`rd_en`/`flush`/`rst_n` with `data_in=i` → scoreboard confirms order is preserved across pointer wrap. Flags must match the model every cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants, flag bundle and width helper for the programmable FIFO family.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 16;
  localparam int unsigned FIFO_DEPTH      = 8;

  // Occupancy status decoded from the count every cycle
  typedef struct packed {
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
  } fifo_flags_t;

  // Count must represent 0..DEPTH inclusive, hence one bit above the pointer width
  function automatic int unsigned count_w(input int unsigned depth);
    return 32'($clog2(depth)) + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_if.sv
// Handshake and status bundle between a FIFO and its producer/consumer.
interface fifo_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH
);
  localparam int unsigned CW = count_w(DEPTH);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CW-1:0]         count;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, wr_ack, overflow, underflow,
    input  full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, wr_ack, overflow, underflow,
    output full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned AW        = 32'($clog2(DEPTH))
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_prog.sv
// Parametrised synchronous FIFO with programmable thresholds, flush and optional FWFT read.
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH,
  parameter int unsigned AF_THRESH  = DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1,
  parameter int unsigned FWFT       = 0
) (
  input  logic  clk,
  input  logic  rst_n,
  fifo_if.slave bus
);

  localparam int unsigned AW = 32'($clog2(DEPTH));
  localparam int unsigned CW = count_w(DEPTH);

  // Reject illegal configurations at elaboration
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "fifo_prog: DEPTH must be a power of two and at least 4");
  end
  if (AE_THRESH < 1 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH - 1) begin : g_bad_thresh
    $fatal(1, "fifo_prog: thresholds must satisfy 1 <= AE_THRESH < AF_THRESH <= DEPTH-1");
  end

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rd_data;
  fifo_flags_t           flags;

  // Status flags are pure decodes of the current occupancy
  always_comb begin
    flags             = '0;
    flags.full        = (count_q == CW'(DEPTH));
    flags.empty       = (count_q == '0);
    flags.almostfull  = (count_q >= CW'(AF_THRESH));
    flags.almostempty = (count_q <= CW'(AE_THRESH));
  end

  // Acceptance is judged against pre-edge flags; flush overrides both requests
  always_comb begin
    wr_acc      = bus.wr_en && !flags.full  && !bus.flush;
    rd_acc      = bus.rd_en && !flags.empty && !bus.flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = wr_acc;
    overflow_d  = bus.wr_en && flags.full  && !bus.flush;
    underflow_d = bus.rd_en && flags.empty && !bus.flush;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // FWFT presents the head directly; registered mode captures it on each pop
  if (FWFT != 0) begin : g_fwft
    assign bus.data_out = flags.empty ? '0 : rd_data;
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    always_comb begin
      data_out_d = data_out_q;
      if (rd_acc) begin
        data_out_d = rd_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_out_q <= '0;
      end else begin
        data_out_q <= data_out_d;
      end
    end

    assign bus.data_out = data_out_q;
  end

  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.count       = count_q;
  assign bus.full        = flags.full;
  assign bus.empty       = flags.empty;
  assign bus.almostfull  = flags.almostfull;
  assign bus.almostempty = flags.almostempty;

endmodule

// File: tb/tb_fifo_prog.sv
// Directed and randomised checks of fifo_prog in registered and FWFT read modes.
module tb_fifo_prog;
  import fifo_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] q [$];
  logic [15:0] m_dout;
  logic        m_ack, m_ovf, m_udf;

  always #5 clk = ~clk;

  fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) ifa ();
  fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) ifb ();

  fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_dut_fwft (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (ifb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step_a(input logic wr, input logic rd, input logic fl, input logic [15:0] din);
    ifa.wr_en   = wr;
    ifa.rd_en   = rd;
    ifa.flush   = fl;
    ifa.data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic wr, input logic rd, input logic fl, input logic [15:0] din);
    ifb.wr_en   = wr;
    ifb.rd_en   = rd;
    ifb.flush   = fl;
    ifb.data_in = din;
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of one clock edge for the registered-read FIFO
  task automatic model_edge(input logic wr, input logic rd, input logic fl, input logic [15:0] din);
    logic m_full, m_empty, wa, ra;
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    if (fl) begin
      q.delete();
      m_ack = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      wa    = wr && !m_full;
      ra    = rd && !m_empty;
      m_ack = wa;
      m_ovf = wr && m_full;
      m_udf = rd && m_empty;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(din);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rst_n_b = 1'b0;
    ifa.wr_en = 1'b0; ifa.rd_en = 1'b0; ifa.flush = 1'b0; ifa.data_in = '0;
    ifb.wr_en = 1'b0; ifb.rd_en = 1'b0; ifb.flush = 1'b0; ifb.data_in = '0;
    #1;
    check("rst_count",  32'(ifa.count), 0);
    check("rst_empty",  ifa.empty, 1);
    check("rst_ae",     ifa.almostempty, 1);
    check("rst_full",   ifa.full, 0);
    check("rst_af",     ifa.almostfull, 0);
    check("rst_dout",   ifa.data_out, 0);
    check("rst_wr_ack", ifa.wr_ack, 0);
    check("rst_fwft_dout", ifb.data_out, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    rst_n_b = 1'b1;

    // Fill 0..7 then one rejected write
    for (int i = 0; i < 8; i++) begin
      step_a(1'b1, 1'b0, 1'b0, 16'(i));
      check("fill_ack",   ifa.wr_ack, 1);
      check("fill_count", 32'(ifa.count), 32'(i + 1));
      check("fill_af",    ifa.almostfull, 32'(i + 1 >= 7));
      check("fill_full",  ifa.full, 32'(i == 7));
      check("fill_ae",    ifa.almostempty, 32'(i + 1 <= 1));
    end
    step_a(1'b1, 1'b0, 1'b0, 16'h0099);
    check("ovf_flag",  ifa.overflow, 1);
    check("ovf_ack",   ifa.wr_ack, 0);
    check("ovf_count", 32'(ifa.count), 8);

    // Drain in order, then one rejected read
    for (int i = 0; i < 8; i++) begin
      step_a(1'b0, 1'b1, 1'b0, 16'h0);
      if (i == 0) check("ovf_pulse", ifa.overflow, 0);
      check("drain_data",  ifa.data_out, 32'(i));
      check("drain_count", 32'(ifa.count), 32'(7 - i));
    end
    check("drain_empty", ifa.empty, 1);
    step_a(1'b0, 1'b1, 1'b0, 16'h0);
    check("udf_flag",  ifa.underflow, 1);
    check("udf_hold",  ifa.data_out, 16'h0007);
    check("udf_count", 32'(ifa.count), 0);

    // Simultaneous requests at empty, mid and full
    step_a(1'b1, 1'b1, 1'b0, 16'h0055);
    check("both0_count", 32'(ifa.count), 1);
    check("both0_udf",   ifa.underflow, 1);
    check("both0_ack",   ifa.wr_ack, 1);
    for (int i = 0; i < 3; i++) step_a(1'b1, 1'b0, 1'b0, 16'(16'h0060 + i));
    check("mid_count", 32'(ifa.count), 4);
    step_a(1'b1, 1'b1, 1'b0, 16'h0063);
    check("both4_count", 32'(ifa.count), 4);
    check("both4_ack",   ifa.wr_ack, 1);
    check("both4_data",  ifa.data_out, 16'h0055);
    check("both4_udf",   ifa.underflow, 0);
    for (int i = 0; i < 4; i++) step_a(1'b1, 1'b0, 1'b0, 16'(16'h0064 + i));
    check("refill_full", ifa.full, 1);
    step_a(1'b1, 1'b1, 1'b0, 16'h0070);
    check("both8_count", 32'(ifa.count), 7);
    check("both8_ovf",   ifa.overflow, 1);
    check("both8_ack",   ifa.wr_ack, 0);
    check("both8_data",  ifa.data_out, 16'h0060);
    step_a(1'b0, 1'b1, 1'b0, 16'h0);
    check("wrap_data1", ifa.data_out, 16'h0061);
    step_a(1'b0, 1'b1, 1'b0, 16'h0);
    check("wrap_data2", ifa.data_out, 16'h0062);
    check("pre_flush_count", 32'(ifa.count), 5);

    // Flush with a concurrent write
    step_a(1'b1, 1'b0, 1'b1, 16'h00BB);
    check("flush_count", 32'(ifa.count), 0);
    check("flush_empty", ifa.empty, 1);
    check("flush_ack",   ifa.wr_ack, 0);
    check("flush_dout",  ifa.data_out, 16'h0062);
    step_a(1'b1, 1'b0, 1'b0, 16'h00C0);
    step_a(1'b0, 1'b1, 1'b0, 16'h0);
    check("post_flush_data", ifa.data_out, 16'h00C0);

    // Asynchronous reset between edges
    for (int i = 0; i < 5; i++) step_a(1'b1, 1'b0, 1'b0, 16'(16'h00D0 + i));
    check("pre_rst_count", 32'(ifa.count), 5);
    ifa.wr_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(ifa.count), 0);
    check("arst_empty", ifa.empty, 1);
    check("arst_ae",    ifa.almostempty, 1);
    check("arst_dout",  ifa.data_out, 0);
    rst_n = 1'b1;
    step_a(1'b1, 1'b0, 1'b0, 16'h00E0);
    step_a(1'b0, 1'b1, 1'b0, 16'h0);
    check("post_rst_data", ifa.data_out, 16'h00E0);

    // First-word-fall-through instance
    step_b(1'b1, 1'b0, 1'b0, 16'hA5A5);
    check("fwft_first",   ifb.data_out, 16'hA5A5);
    check("fwft_count1",  32'(ifb.count), 1);
    step_b(1'b1, 1'b0, 1'b0, 16'h1234);
    check("fwft_head",    ifb.data_out, 16'hA5A5);
    step_b(1'b0, 1'b1, 1'b0, 16'h0);
    check("fwft_pop",     ifb.data_out, 16'h1234);
    step_b(1'b0, 1'b1, 1'b0, 16'h0);
    check("fwft_empty",   ifb.empty, 1);
    check("fwft_zero",    ifb.data_out, 0);
    step_b(1'b0, 1'b1, 1'b0, 16'h0);
    check("fwft_udf",     ifb.underflow, 1);

    // Random soak against the queue model
    begin
      int unsigned bias_w, bias_r;
      logic wr, rd, fl;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      q.delete();
      m_dout = '0; m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      bias_w = 50;
      bias_r = 50;
      for (int i = 0; i < 30000; i++) begin
        if (i % 500 == 0) begin
          bias_w = $urandom_range(20, 80);
          bias_r = $urandom_range(20, 80);
        end
        if ($urandom_range(0, 999) < 3) begin
          rst_n = 1'b0;
          #1;
          q.delete();
          m_dout = '0; m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
          check("soak_rst_count", 32'(ifa.count), 0);
          check("soak_rst_dout",  ifa.data_out, 0);
          rst_n = 1'b1;
        end
        wr = ($urandom_range(0, 99) < bias_w);
        rd = ($urandom_range(0, 99) < bias_r);
        fl = ($urandom_range(0, 99) < 2);
        step_a(wr, rd, fl, 16'(i));
        model_edge(wr, rd, fl, 16'(i));
        check("soak_count", 32'(ifa.count), 32'(q.size()));
        check("soak_flags",
              {ifa.full, ifa.empty, ifa.almostfull, ifa.almostempty},
              {q.size() == DEPTH, q.size() == 0, q.size() >= DEPTH - 1, q.size() <= 1});
        check("soak_pulses", {ifa.wr_ack, ifa.overflow, ifa.underflow}, {m_ack, m_ovf, m_udf});
        check("soak_dout", ifa.data_out, m_dout);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
